// File: rtl/i2c_master_arbiter.sv
// Round-robin arbiter that shares one i2c_master among NUM_REQ requesters and
// detects transaction end from the bus lines. Define I2C_ARB_TIMEOUT_EN to add a watchdog.
module i2c_master_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int IDX_W          = $clog2(NUM_REQ),
    parameter int IDLE_CYCLES    = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [NUM_REQ-1:0]   req_rw,
    input  logic [7*NUM_REQ-1:0] req_addr,
    input  logic [8*NUM_REQ-1:0] req_wdata,
    input  logic                 bus_scl,
    input  logic                 bus_sda,
    output logic [NUM_REQ-1:0]   gnt,
    output logic [IDX_W-1:0]     gnt_id,
    output logic                 m_start,
    output logic                 m_stop,
    output logic                 m_rw,
    output logic [6:0]           m_addr,
    output logic [7:0]           m_wdata,
    output logic                 done,
    output logic                 err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT_ACTIVE,
        S_WAIT_IDLE,
        S_DONE
    } state_t;

    state_t               state_q;
    logic [IDX_W-1:0]     ptr_q;
    logic [NUM_REQ-1:0]   gnt_q;
    logic [IDX_W-1:0]     gnt_id_q;
    logic                 m_start_q;
    logic                 m_stop_q;
    logic                 m_rw_q;
    logic [6:0]           m_addr_q;
    logic [7:0]           m_wdata_q;
    logic                 done_q;
    logic [3:0]           idle_q;
    logic [3:0]           idle_d;
    logic                 idle_hit;
    logic                 timeout;
    logic                 finish;

    logic [NUM_REQ-1:0]   rot;
    int                   pick_off;
    int                   pick_sum;
    logic                 pick_found;
    logic [IDX_W-1:0]     pick_idx;
    logic                 sel_rw;
    logic [6:0]           sel_addr;
    logic [7:0]           sel_wdata;

    // Rotate requests so bit 0 is the pointer; the lowest set bit is the winner.
    always_comb begin
        rot        = NUM_REQ'({req, req} >> ptr_q);
        pick_found = |req;
        pick_off   = 0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (rot[i]) pick_off = i;
        end
        pick_sum = int'(ptr_q) + pick_off;
        if (pick_sum >= NUM_REQ) pick_sum = pick_sum - NUM_REQ;
        pick_idx  = IDX_W'(pick_sum);
        sel_rw    = 1'b0;
        sel_addr  = 7'd0;
        sel_wdata = 8'd0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_idx == IDX_W'(i)) begin
                sel_rw    = req_rw[i];
                sel_addr  = req_addr[7*i +: 7];
                sel_wdata = req_wdata[8*i +: 8];
            end
        end
    end

    assign idle_d   = (bus_scl && bus_sda) ? idle_q + 4'd1 : 4'd0;
    assign idle_hit = (idle_d == 4'(IDLE_CYCLES));
    assign finish   = ((state_q == S_WAIT_IDLE) && idle_hit) || timeout;

`ifdef I2C_ARB_TIMEOUT_EN
    localparam int WDOG_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WDOG_W-1:0] wdog_q;
    logic [WDOG_W-1:0] wdog_d;
    logic              err_q;

    assign wdog_d  = wdog_q + WDOG_W'(1);
    assign timeout = ((state_q == S_WAIT_ACTIVE) || (state_q == S_WAIT_IDLE)) &&
                     (wdog_d == WDOG_W'(TIMEOUT_CYCLES));
    assign err     = err_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wdog_q <= '0;
            err_q  <= 1'b0;
        end else begin
            err_q <= timeout;
            if (state_q == S_LAUNCH)
                wdog_q <= '0;
            else if ((state_q == S_WAIT_ACTIVE) || (state_q == S_WAIT_IDLE))
                wdog_q <= wdog_d;
        end
    end
`else
    assign timeout = 1'b0;
    assign err     = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            ptr_q     <= '0;
            gnt_q     <= '0;
            gnt_id_q  <= '0;
            m_start_q <= 1'b0;
            m_stop_q  <= 1'b0;
            m_rw_q    <= 1'b0;
            m_addr_q  <= 7'd0;
            m_wdata_q <= 8'd0;
            done_q    <= 1'b0;
            idle_q    <= 4'd0;
        end else begin
            m_start_q <= 1'b0;
            done_q    <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (pick_found) begin
                        state_q   <= S_LAUNCH;
                        gnt_q     <= NUM_REQ'(1) << pick_idx;
                        gnt_id_q  <= pick_idx;
                        m_start_q <= 1'b1;
                        m_stop_q  <= 1'b1;
                        m_rw_q    <= sel_rw;
                        m_addr_q  <= sel_addr;
                        m_wdata_q <= sel_wdata;
                    end
                end
                S_LAUNCH: begin
                    state_q <= S_WAIT_ACTIVE;
                    idle_q  <= 4'd0;
                end
                S_WAIT_ACTIVE: begin
                    if (!bus_scl) state_q <= S_WAIT_IDLE;
                end
                S_WAIT_IDLE: begin
                    idle_q <= idle_d;
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
            // Normal completion and watchdog expiry share the same exit path.
            if (finish) begin
                state_q  <= S_DONE;
                done_q   <= 1'b1;
                gnt_q    <= '0;
                m_stop_q <= 1'b0;
                ptr_q    <= (gnt_id_q == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_id_q + IDX_W'(1);
            end
        end
    end

    assign gnt     = gnt_q;
    assign gnt_id  = gnt_id_q;
    assign m_start = m_start_q;
    assign m_stop  = m_stop_q;
    assign m_rw    = m_rw_q;
    assign m_addr  = m_addr_q;
    assign m_wdata = m_wdata_q;
    assign done    = done_q;

endmodule

// File: tb/tb_i2c_master_arbiter.sv
// Directed bench for i2c_master_arbiter: table of single transactions plus
// hand-written glitch, reset, watchdog and contention sequences.
module tb_i2c_master_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req;
    logic [3:0]  req_rw;
    logic [27:0] req_addr;
    logic [31:0] req_wdata;
    logic        bus_scl;
    logic        bus_sda;
    logic [3:0]  gnt;
    logic [1:0]  gnt_id;
    logic        m_start;
    logic        m_stop;
    logic        m_rw;
    logic [6:0]  m_addr;
    logic [7:0]  m_wdata;
    logic        done;
    logic        err;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    i2c_master_arbiter #(
        .NUM_REQ(4),
        .IDX_W(2),
        .IDLE_CYCLES(4),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk),
        .reset(reset),
        .req(req),
        .req_rw(req_rw),
        .req_addr(req_addr),
        .req_wdata(req_wdata),
        .bus_scl(bus_scl),
        .bus_sda(bus_sda),
        .gnt(gnt),
        .gnt_id(gnt_id),
        .m_start(m_start),
        .m_stop(m_stop),
        .m_rw(m_rw),
        .m_addr(m_addr),
        .m_wdata(m_wdata),
        .done(done),
        .err(err)
    );

    typedef struct {
        logic [3:0] req;
        logic [3:0] rw;
        logic [3:0] exp_gnt;
        logic [1:0] exp_id;
        logic       exp_rw;
        logic [6:0] exp_addr;
        logic [7:0] exp_wdata;
    } vec_t;

    vec_t vecs[9];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic count_to_done(input int bound, output int n);
        n = 0;
        while (done !== 1'b1 && n < bound) begin
            tick;
            n++;
        end
    endtask

    task automatic run_txn(input vec_t v);
        int n;
        req    = v.req;
        req_rw = v.rw;
        tick;
        chk("gnt", 32'(gnt), 32'(v.exp_gnt));
        chk("gnt_id", 32'(gnt_id), 32'(v.exp_id));
        chk("m_start", 32'(m_start), 32'd1);
        chk("m_stop", 32'(m_stop), 32'd1);
        chk("m_rw", 32'(m_rw), 32'(v.exp_rw));
        chk("m_addr", 32'(m_addr), 32'(v.exp_addr));
        chk("m_wdata", 32'(m_wdata), 32'(v.exp_wdata));
        // Dropping req and flipping rw after launch must not disturb the transaction.
        req     = 4'b0000;
        req_rw  = ~v.rw;
        bus_scl = 1'b0;
        bus_sda = 1'b0;
        tick;
        chk("m_start_pulse", 32'(m_start), 32'd0);
        chk("m_rw_hold", 32'(m_rw), 32'(v.exp_rw));
        tick;
        bus_scl = 1'b1;
        bus_sda = 1'b1;
        count_to_done(20, n);
        chk("idle_len", 32'(n), 32'd4);
        chk("gnt_done", 32'(gnt), 32'd0);
        chk("m_stop_done", 32'(m_stop), 32'd0);
        chk("gnt_id_keep", 32'(gnt_id), 32'(v.exp_id));
        chk("m_addr_keep", 32'(m_addr), 32'(v.exp_addr));
        tick;
        chk("done_single", 32'(done), 32'd0);
        req_rw = 4'b0000;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got stuck, expected completion");
        $fatal(1);
    end

    initial begin
        int n;
        int seen;
        int gap;
        vec_t v;

        vecs[0] = '{4'b0010, 4'b0101, 4'b0010, 2'd1, 1'b0, 7'h50, 8'hA5};
        vecs[1] = '{4'b1111, 4'b0101, 4'b0100, 2'd2, 1'b1, 7'h2B, 8'h96};
        vecs[2] = '{4'b1111, 4'b1111, 4'b1000, 2'd3, 1'b1, 7'h1C, 8'h3C};
        vecs[3] = '{4'b1111, 4'b0000, 4'b0001, 2'd0, 1'b0, 7'h11, 8'h0F};
        vecs[4] = '{4'b1111, 4'b0010, 4'b0010, 2'd1, 1'b1, 7'h50, 8'hA5};
        vecs[5] = '{4'b0001, 4'b0001, 4'b0001, 2'd0, 1'b1, 7'h11, 8'h0F};
        vecs[6] = '{4'b1000, 4'b0000, 4'b1000, 2'd3, 1'b0, 7'h1C, 8'h3C};
        vecs[7] = '{4'b1001, 4'b1000, 4'b0001, 2'd0, 1'b0, 7'h11, 8'h0F};
        vecs[8] = '{4'b1001, 4'b1000, 4'b1000, 2'd3, 1'b1, 7'h1C, 8'h3C};

        reset     = 1'b1;
        req       = 4'b0000;
        req_rw    = 4'b0000;
        req_addr  = {7'h1C, 7'h2B, 7'h50, 7'h11};
        req_wdata = {8'h3C, 8'h96, 8'hA5, 8'h0F};
        bus_scl   = 1'b1;
        bus_sda   = 1'b1;
        tick;
        tick;
        reset = 1'b0;
        tick;
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_gnt_id", 32'(gnt_id), 32'd0);
        chk("rst_m_start", 32'(m_start), 32'd0);
        chk("rst_m_stop", 32'(m_stop), 32'd0);
        chk("rst_m_rw", 32'(m_rw), 32'd0);
        chk("rst_m_addr", 32'(m_addr), 32'd0);
        chk("rst_m_wdata", 32'(m_wdata), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);

        for (int i = 0; i < 9; i++) begin
            run_txn(vecs[i]);
        end

        // Glitch: 3 idle cycles, one SDA-low cycle, then 4 fresh idle cycles needed.
        req    = 4'b0100;
        req_rw = 4'b0000;
        tick;
        chk("glitch_id", 32'(gnt_id), 32'd2);
        req     = 4'b0000;
        bus_scl = 1'b0;
        tick;
        tick;
        bus_scl = 1'b1;
        bus_sda = 1'b1;
        seen    = 0;
        repeat (3) begin
            tick;
            if (done === 1'b1) seen++;
        end
        bus_sda = 1'b0;
        tick;
        if (done === 1'b1) seen++;
        chk("glitch_early_done", 32'(seen), 32'd0);
        bus_sda = 1'b1;
        count_to_done(20, n);
        chk("glitch_idle_len", 32'(n), 32'd4);
        tick;

        // Reset in WAIT_IDLE: pointer (3 before reset) must restart at 0.
        req = 4'b0010;
        tick;
        chk("rmid_id", 32'(gnt_id), 32'd1);
        req     = 4'b0000;
        bus_scl = 1'b0;
        tick;
        tick;
        bus_scl = 1'b1;
        tick;
        reset = 1'b1;
        #2;
        chk("rmid_gnt", 32'(gnt), 32'd0);
        chk("rmid_m_stop", 32'(m_stop), 32'd0);
        chk("rmid_done", 32'(done), 32'd0);
        tick;
        reset = 1'b0;
        seen  = 0;
        repeat (6) begin
            tick;
            if (done === 1'b1) seen++;
        end
        chk("rmid_no_done", 32'(seen), 32'd0);
        v = '{4'b1100, 4'b0000, 4'b0100, 2'd2, 1'b0, 7'h2B, 8'h96};
        run_txn(v);

        // Watchdog: SCL never drops.
        req = 4'b0001;
        tick;
        chk("wd_id", 32'(gnt_id), 32'd0);
        chk("wd_start", 32'(m_start), 32'd1);
        req = 4'b0000;
        count_to_done(40, n);
`ifdef I2C_ARB_TIMEOUT_EN
        chk("wd_latency", 32'(n), 32'd17);
        chk("wd_err", 32'(err), 32'd1);
        tick;
        chk("wd_err_single", 32'(err), 32'd0);
`else
        chk("wd_no_done", 32'(n), 32'd40);
        chk("wd_err", 32'(err), 32'd0);
`endif

        // Contention: all requesting from pointer 0, gap of 2 cycles after each done.
        reset = 1'b1;
        tick;
        reset   = 1'b0;
        bus_scl = 1'b1;
        bus_sda = 1'b1;
        req     = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            gap = 0;
            while (gnt === 4'b0000 && gap < 10) begin
                tick;
                gap++;
            end
            if (g > 0) chk("rr_gap", 32'(gap), 32'd2);
            chk("rr_id", 32'(gnt_id), 32'(g % 4));
            bus_scl = 1'b0;
            tick;
            tick;
            bus_scl = 1'b1;
            count_to_done(20, n);
            chk("rr_idle_len", 32'(n), 32'd4);
        end
        req = 4'b0000;
        tick;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
